// File: rtl/uart_rx_byte_source.sv
// 8-N-1 UART receiver that pushes each good byte into a downstream byte queue.
// Optional even-parity framing is enabled by defining UART_RX_PARITY_EN.
module uart_rx_byte_source #(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       q_full,
    input  logic       clear_err,
    output logic       push,
    output logic [7:0] dout,
    output logic       busy,
    output logic       overflow,
    output logic       frame_err,
    output logic [2:0] fsm_state
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
    logic par_bit;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    state_t        state;
    logic          rx_m;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    sh;

    assign fsm_state = state;

    // Synchronizer resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            sh         <= '0;
            push       <= 1'b0;
            dout       <= 8'h00;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            push <= 1'b0;
            // Clear comes first so a same-cycle flag set below takes precedence.
            if (clear_err) begin
                overflow  <= 1'b0;
                frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
            if (cnt != '0) cnt <= cnt - 1'b1;

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        cnt   <= HALF;
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == '0) begin
                        if (!rx_s) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                            cnt     <= FULL;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (cnt == '0) begin
                        sh      <= {rx_s, sh[7:1]};
                        cnt     <= FULL;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt == '0) begin
                        par_bit <= rx_s;
                        cnt     <= FULL;
                        state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt == '0) begin
                        if (rx_s) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (^{sh, par_bit}) parity_err <= 1'b1;
                            else
`endif
                            if (q_full) begin
                                overflow <= 1'b1;
                            end else begin
                                push <= 1'b1;
                                dout <= sh;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end
                end
                // Held-low line: wait for idle so one break yields one error event.
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte_source.sv
// Directed plus randomized bench for uart_rx_byte_source with CLK_DIV=8.
// Push timing and byte contents are predicted from frame start edges and framing rules.
module tb_uart_rx_byte_source;

    localparam int CLK_DIV  = 8;
    localparam int STOP_OFS = 2 + CLK_DIV / 2 + 9 * CLK_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       q_full = 1'b0;
    logic       clear_err = 1'b0;
    logic       push;
    logic [7:0] dout;
    logic       busy;
    logic       overflow;
    logic       frame_err;
    logic [2:0] fsm_state;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_byte_source #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .q_full    (q_full),
        .clear_err (clear_err),
        .push      (push),
        .dout      (dout),
        .busy      (busy),
        .overflow  (overflow),
        .frame_err (frame_err),
        .fsm_state (fsm_state)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    logic [7:0] got_q[$];
    int         got_cyc_q[$];

    int   dbl = 0;
    logic prev_push = 1'b0;
    int   fe_events = 0;
    logic prev_fe = 1'b0;
    int   gap_cnt = 0;
    int   last_gap = -1;

    always @(negedge clk) begin
        if (push) begin
            got_q.push_back(dout);
            got_cyc_q.push_back(cyc);
            if (prev_push) dbl++;
            last_gap = gap_cnt;
            gap_cnt = 0;
        end
        if (!busy) gap_cnt++;
        if (frame_err && !prev_fe) fe_events++;
        prev_push = push;
        prev_fe = frame_err;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge; returns #1 after the last edge of the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop, output int k);
        k = cyc + 1;
        rx = 1'b0;
        idle(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CLK_DIV);
        end
        rx = stop;
        idle(CLK_DIV);
    endtask

    task automatic expect_push(input logic [7:0] b, input int k);
        exp_q.push_back(b);
        exp_cyc_q.push_back(k + STOP_OFS);
    endtask

    task automatic check_pushes(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            chk({tag, "_dout"}, got_q.pop_front(), exp_q.pop_front());
            chk({tag, "_cycle"}, got_cyc_q.pop_front(), exp_cyc_q.pop_front());
        end
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        idle(1);
        clear_err = 1'b0;
    endtask

    initial begin
        int         k;
        int         k2;
        int         fe0;
        logic [7:0] b;
        logic [7:0] b99;
        logic       stop;
        logic       full;

        // Reset state
        idle(3);
        chk("rst_push", push, 1'b0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_fe", frame_err, 1'b0);
        reset = 1'b0;
        idle(4);
        chk("post_rst_busy", busy, 1'b0);

        // Single good byte
        send_byte(8'hA5, 1'b1, k);
        expect_push(8'hA5, k);
        check_pushes("a5");
        chk("a5_ovf", overflow, 1'b0);
        chk("a5_fe", frame_err, 1'b0);
        idle(4);

        // Back-to-back frames, no idle gap
        send_byte(8'h00, 1'b1, k);
        expect_push(8'h00, k);
        send_byte(8'hFF, 1'b1, k2);
        expect_push(8'hFF, k2);
        check_pushes("b2b");
        chk("b2b_busy_gap", last_gap, CLK_DIV / 2);
        idle(4);

        // Two-cycle low glitch
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(3);
        chk("glitch_busy_start", busy, 1'b1);
        idle(10);
        chk("glitch_busy_end", busy, 1'b0);
        check_pushes("glitch");
        chk("glitch_fe", frame_err, 1'b0);
        chk("glitch_ovf", overflow, 1'b0);

        // Framing error followed by a held-low line
        fe0 = fe_events;
        send_byte(8'h3C, 1'b0, k);
        idle(40 - CLK_DIV);
        chk("brk_fe", frame_err, 1'b1);
        chk("brk_busy", busy, 1'b1);
        rx = 1'b1;
        idle(6);
        chk("brk_busy_end", busy, 1'b0);
        chk("brk_fe_events", fe_events - fe0, 1);
        check_pushes("brk");
        pulse_clear();
        chk("brk_fe_clear", frame_err, 1'b0);

        // Overflow on a full queue, then a good byte
        q_full = 1'b1;
        send_byte(8'h55, 1'b1, k);
        q_full = 1'b0;
        chk("ovf_set", overflow, 1'b1);
        check_pushes("ovf");
        send_byte(8'h12, 1'b1, k);
        expect_push(8'h12, k);
        check_pushes("after_ovf");
        chk("ovf_sticky", overflow, 1'b1);
        pulse_clear();
        chk("ovf_clear", overflow, 1'b0);

        // Reset in the middle of the 4th data bit
        b99 = 8'h99;
        rx = 1'b0;
        idle(CLK_DIV);
        for (int i = 0; i < 3; i++) begin
            rx = b99[i];
            idle(CLK_DIV);
        end
        rx = b99[3];
        idle(CLK_DIV / 2);
        reset = 1'b1;
        #1;
        chk("midrst_push", push, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_dout", dout, 8'h00);
        chk("midrst_ovf", overflow, 1'b0);
        chk("midrst_fe", frame_err, 1'b0);
        rx = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2 * CLK_DIV);
        chk("midrst_idle_busy", busy, 1'b0);
        check_pushes("midrst");
        send_byte(8'h99, 1'b1, k);
        expect_push(8'h99, k);
        check_pushes("rearm");

        // Randomized frames: random byte, stop level and queue-full state
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            full = ($urandom_range(0, 3) == 0);
            q_full = full;
            send_byte(b, stop, k);
            q_full = 1'b0;
            if (stop && !full) expect_push(b, k);
            chk("rnd_ovf", overflow, stop && full);
            chk("rnd_fe", frame_err, !stop);
            check_pushes("rnd");
            rx = 1'b1;
            idle(3 + $urandom_range(0, 4));
            pulse_clear();
            chk("rnd_clear", {overflow, frame_err}, 2'b00);
        end

        chk("no_double_push", dbl, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte_source.md
# uart_rx_byte_source

Asynchronous serial (8-N-1) receiver that deserializes bytes from the host link and pushes each good byte into the downstream 8-entry byte queue through its push/din/full interface. It sits between the board's RX pin and the command queue of the programmer. The receiver itself has no ready/valid back-pressure. A byte that arrives while the queue is full is dropped and flagged.

## Interface
- CLK_DIV, 434: clock cycles per bit period; even integer, minimum 8 (434 gives 50 MHz / 115200).
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial line, idle high, asynchronous to clk.
- q_full  in  1  full flag from the downstream queue.
- push  out  1  one-cycle write strobe to the queue.
- dout  out  8  received byte; valid whenever push is high and held until the next push.
- busy  out  1  high while the FSM is not in IDLE.
- overflow  out  1  sticky: a good byte was dropped because q_full was high.
- frame_err  out  1  sticky: the stop bit was sampled low.
- clear_err  in  1  synchronous clear of both sticky flags.

## Operation
- rx passes through a two-flop synchronizer that resets to 1; rx_s is the second flop.
- Bit counter width is $clog2(CLK_DIV). It decrements every cycle; the FSM acts when it reaches 0.
- FSM states:
  - IDLE: when rx_s==0, go to START and load counter = CLK_DIV/2-1.
  - START: at counter 0, sample rx_s. If 0, go to DATA with bit index 0 and counter = CLK_DIV-1. If 1, this was a glitch; return to IDLE with no flag.
  - DATA: at each counter 0, shift rx_s into the shift register, LSB first, and reload the counter. After bit 7, go to STOP (or PARITY when parity is enabled).
  - STOP: at counter 0, sample rx_s.
    - 1 and q_full==0: push<=1, dout<=byte, go to IDLE.
    - 1 and q_full==1: no push, overflow<=1, go to IDLE.
    - 0: no push, frame_err<=1, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line from producing repeated bytes.
- Returning to IDLE at mid-stop-bit lets a start bit begin directly after the stop bit.
- q_full is examined only in the single cycle of the stop-bit sample.
- If clear_err and a flag set occur in the same cycle, the set wins.
- Reset values: push=0, dout=8'h00, busy=0, overflow=0, frame_err=0, FSM=IDLE, counter=0.
- Reset asserted mid-frame aborts the frame immediately with no push. After release, the FSM re-arms in IDLE. If rx is still low at release, it is treated as a new start edge.

## Timing
- Let edge k be the first rising clk edge at which rx is sampled low.
- rx_s shows 0 after edge k+1. The FSM enters START at edge k+2.
- Start-bit sample: edge k+2+CLK_DIV/2. Data bit n sample: that edge plus (n+1)*CLK_DIV.
- Stop sample is at edge k+2+CLK_DIV/2+9*CLK_DIV. push is high for exactly the one following cycle, and dout is valid in that same cycle.
- With CLK_DIV=8, push is high in the cycle after edge k+78.
- push is never high in two consecutive cycles.
- Sustained back-to-back frames produce one push per 10*CLK_DIV cycles, well inside the queue's one-push-per-cycle capacity.
- busy rises after edge k+2 and falls after the stop sample edge.

## Configuration
- UART_RX_PARITY_EN defined:
  - A PARITY state follows DATA. It samples one even-parity bit one CLK_DIV after bit 7.
  - The stop sample moves to k+2+CLK_DIV/2+10*CLK_DIV.
  - A port parity_err (out 1, sticky, reset 0, cleared by clear_err) is added.
  - A parity mismatch with a good stop bit drops the byte: no push, parity_err<=1, go to IDLE. Overflow is not checked.
- UART_RX_PARITY_EN undefined: 8-N-1 framing only. The PARITY state, parity logic and the parity_err port do not exist.

## Test plan
- CLK_DIV=8, q_full=0, send 0xA5 with a 1 stop bit -> push high for exactly one cycle after edge k+78, dout=8'hA5, both flags 0.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two pushes 80 cycles apart with dout 00 then FF; busy drops between them for under CLK_DIV cycles.
- rx low pulse of 2 cycles -> FSM enters START, sees 1 at mid-bit, returns to IDLE; no push, no flag.
- Send 0x3C with the stop bit forced 0, then hold rx low for 40 cycles -> frame_err=1, no push, busy high until rx returns high, only one frame_err event. Pulse clear_err -> frame_err=0.
- q_full=1 during the stop sample of 0x55 -> no push, overflow=1. Next byte 0x12 with q_full=0 -> push with dout=8'h12; overflow stays 1.
- Assert reset at the 4th data bit of 0x99 -> push/busy/dout/flags all 0 immediately. Release with rx high, send 0x99 -> one clean push with dout=8'h99.
